rv_multicycle_ctrl: RTL and testbench
=====================================

// Module: rv_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I datapath (Pc, RamSp prog/data mem, Regfile, Alu, WB mux).
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction class and drives all datapath selects/enables.
//  Handles synchronous IMEM read latency, DMEM ready handshake, and traps on illegal/bus-error/halt.
// PARAMETERS
//  IMEM_LATENCY  1    cycles from Pc change to valid prog-mem RdData (0..15)
//  MEM_TIMEOUT   255  max MEM-state cycles waiting DmemRdy before BusErr; 0 disables timeout
// PORTS
//  clk           in   1   clock
//  Reset         in   1   synchronous, active-high
//  Instr         in   32  instruction register contents (loaded by IrWrEn)
//  BrTaken       in   1   datapath branch-compare result, valid in EXEC
//  DmemRdy       in   1   data mem access complete this cycle
//  PcWrEn        out  1   load PcNxt into Pc
//  IrWrEn        out  1   load prog-mem RdData into IR
//  JalPcSel      out  1   PcNxt = AluOut
//  BrPcSel       out  1   PcNxt = Pc + BrPcOff
//  AuipcSel      out  1   AluOp1 = Pc
//  Op2Sel        out  1   AluOp2 = ImmExt
//  RegWb         out  2   WB mux select (SEL_REG_WB_ALU/DMEM/PC/IMM); PC selects link value Pc+4
//  RegWrEn       out  1   regfile write
//  DmemRdEn      out  1   data mem read request
//  DmemWrEn      out  1   data mem write request
//  InstrRetired  out  1   1-cycle pulse on final cycle of each instruction
//  Halt          out  1   sticky: ECALL/EBREAK executed
//  IllegalInstr  out  1   sticky: unknown opcode or Instr[1:0]!=2'b11
//  BusErr        out  1   sticky: MEM_TIMEOUT expired
// BEHAVIOUR
//  - Reset: state FETCH, counters 0, sticky flags 0. All enables/selects/RegWb 0 during Reset cycle
//    (outputs masked by Reset combinationally) and in first FETCH cycle. Reset from any state -> FETCH.
//  - Outputs: combinational decode of state + Instr (Moore per state); no output registers.
//  - FETCH: lasts IMEM_LATENCY+1 cycles (counter); IrWrEn in last cycle -> DECODE.
//  - DECODE: classify opcode; illegal -> TRAP; SYSTEM funct3=0 -> HALT; LUI/FENCE -> WB; else -> EXEC.
//  - EXEC: Op2Sel=1 except OP/BRANCH; AuipcSel=1 for AUIPC/JAL.
//    BRANCH: PcWrEn=1, BrPcSel=BrTaken, retire -> FETCH. LOAD/STORE -> MEM. others -> WB.
//  - MEM: DmemRdEn (LOAD) or DmemWrEn (STORE) held until DmemRdy=1. LOAD -> WB; STORE: PcWrEn, retire -> FETCH.
//    Timeout counter: reaching MEM_TIMEOUT cycles with DmemRdy=0 -> TRAP, BusErr=1, enables drop.
//  - WB: RegWrEn=1 (rd==x0 still asserted; Regfile ignores). RegWb: OP/OP-IMM/AUIPC=ALU, LOAD=DMEM,
//    JAL/JALR=PC, LUI=IMM. FENCE: RegWrEn=0. PcWrEn=1; JalPcSel=1 for JAL/JALR (link uses old Pc, same edge). Retire.
//  - Latencies (IMEM_LATENCY=1, DmemRdy=1): LUI/BRANCH 4, OP/AUIPC/JAL/JALR/STORE 5, LOAD 6 cycles.
//  - HALT/TRAP: terminal until Reset; all enables 0; Halt or IllegalInstr/BusErr held 1.
//  - Exactly one of PcWrEn-with-Pc+4, BrPcSel, JalPcSel path per instruction; PcWrEn never outside final state.
// STRUCTURE
//  - Rv32iPkg: opcode constants (OPC_LUI..OPC_SYSTEM), ctrl_state_e {FETCH,DECODE,EXEC,MEM,WB,HALT,TRAP},
//    instr class enum, SEL_REG_WB_* constants (moved from top level).
//  - Sub-module rv_ctrl_decode: combinational Instr -> class/illegal/halt; FSM + counters in this module.
// TESTING
//  - ADDI x1,x0,5 (0x00500093): cycles 0-1 FETCH, IrWrEn@1, RegWrEn+RegWb=ALU+Op2Sel @4, PcWrEn@4, retire@4.
//  - LW with DmemRdy low 3 cycles: DmemRdEn held 4 MEM cycles, WB RegWb=DMEM, total 9 cycles.
//  - BEQ BrTaken=1 -> EXEC PcWrEn=1 BrPcSel=1; BrTaken=0 -> BrPcSel=0; both 4 cycles, no RegWrEn.
//  - JAL: WB JalPcSel=1, RegWb=PC, RegWrEn=1, AuipcSel=1 in EXEC; opcode 0x7F -> IllegalInstr=1, enables 0 forever.
//  - SW, DmemRdy stuck 0, MEM_TIMEOUT=8: DmemWrEn 8 cycles then BusErr=1; Reset -> FETCH, flags clear.
//  - Reset asserted in MEM with DmemWrEn high: DmemWrEn=0 same cycle, FETCH next; ECALL -> Halt=1 sticky.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM
// states, instruction classes and write-back mux selects.
package rv_multicycle_ctrl_pkg;

   // Base-ISA major opcodes (Instr[6:0])
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Write-back mux selects; PC selects the link value Pc+4
   localparam logic [1:0] SEL_REG_WB_ALU  = 2'd0;
   localparam logic [1:0] SEL_REG_WB_DMEM = 2'd1;
   localparam logic [1:0] SEL_REG_WB_PC   = 2'd2;
   localparam logic [1:0] SEL_REG_WB_IMM  = 2'd3;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT,
      TRAP
   } ctrl_state_e;

   // CLS_ENV covers ECALL/EBREAK (SYSTEM with funct3 == 0)
   typedef enum logic [3:0] {
      CLS_LUI,
      CLS_AUIPC,
      CLS_JAL,
      CLS_JALR,
      CLS_BRANCH,
      CLS_LOAD,
      CLS_STORE,
      CLS_OP_IMM,
      CLS_OP,
      CLS_FENCE,
      CLS_ENV,
      CLS_ILLEGAL
   } instr_class_e;

   // Write-back source for each class that writes the register file
   function automatic logic [1:0] wb_sel(input instr_class_e cls);
      logic [1:0] sel;
      sel = SEL_REG_WB_ALU;
      case (cls)
         CLS_LOAD:          sel = SEL_REG_WB_DMEM;
         CLS_JAL, CLS_JALR: sel = SEL_REG_WB_PC;
         CLS_LUI:           sel = SEL_REG_WB_IMM;
         default:           sel = SEL_REG_WB_ALU;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_decode.sv
// Combinational instruction classifier: maps the IR contents onto one
// instruction class, flagging anything the datapath cannot execute.
module rv_multicycle_ctrl_decode
   import rv_multicycle_ctrl_pkg::*;
(
   input  logic [31:0]  i_instr,
   output instr_class_e o_class
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic       w_unused_fields;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];

   // Register specifiers and immediates are the datapath's business
   assign w_unused_fields = ^{i_instr[31:15], i_instr[11:7]};

   // Classify the opcode; compressed encodings (Instr[1:0] != 2'b11) are illegal
   always_comb begin
      // NOTE: give every combinationally assigned signal a default first so
      // no path through the case leaves it unassigned and infers a latch.
      o_class = CLS_ILLEGAL;
      if (w_opcode[1:0] == 2'b11) begin
         case (w_opcode)
            OPC_LUI:      o_class = CLS_LUI;
            OPC_AUIPC:    o_class = CLS_AUIPC;
            OPC_JAL:      o_class = CLS_JAL;
            OPC_JALR:     o_class = CLS_JALR;
            OPC_BRANCH:   o_class = CLS_BRANCH;
            OPC_LOAD:     o_class = CLS_LOAD;
            OPC_STORE:    o_class = CLS_STORE;
            OPC_OP_IMM:   o_class = CLS_OP_IMM;
            OPC_OP:       o_class = CLS_OP;
            OPC_MISC_MEM: o_class = CLS_FENCE;
            // CSR forms have no datapath support and trap as illegal
            OPC_SYSTEM:   o_class = (w_funct3 == 3'b000) ? CLS_ENV : CLS_ILLEGAL;
            default:      o_class = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB per instruction class, waits out the prog-mem
// read latency and the data-mem handshake, and parks in HALT or TRAP on
// ECALL/EBREAK, illegal encodings or a data-mem timeout.
module rv_multicycle_ctrl
   import rv_multicycle_ctrl_pkg::*;
#(
   parameter int IMEM_LATENCY = 1,    // 0..15
   parameter int MEM_TIMEOUT  = 255   // 0 disables the timeout
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        BrTaken,
   input  logic        DmemRdy,
   output logic        PcWrEn,
   output logic        IrWrEn,
   output logic        JalPcSel,
   output logic        BrPcSel,
   output logic        AuipcSel,
   output logic        Op2Sel,
   output logic [1:0]  RegWb,
   output logic        RegWrEn,
   output logic        DmemRdEn,
   output logic        DmemWrEn,
   output logic        InstrRetired,
   output logic        Halt,
   output logic        IllegalInstr,
   output logic        BusErr
);

   localparam int                   MEM_CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [3:0]           FETCH_LAST = 4'(IMEM_LATENCY);
   localparam logic [MEM_CNT_W-1:0] MEM_LAST   = (MEM_TIMEOUT > 0) ? MEM_CNT_W'(MEM_TIMEOUT - 1) : '0;
   localparam bit                   TIMEOUT_EN = (MEM_TIMEOUT > 0);

   ctrl_state_e          r_state;
   ctrl_state_e          w_state_nxt;
   logic [3:0]           r_fetch_cnt;
   logic [MEM_CNT_W-1:0] r_mem_cnt;
   logic                 r_halt;
   logic                 r_illegal;
   logic                 r_bus_err;
   logic                 w_set_halt;
   logic                 w_set_illegal;
   logic                 w_set_bus_err;
   instr_class_e         w_class;
   logic                 w_fetch_done;
   logic                 w_mem_expired;
   logic                 w_alu_phase;

   rv_multicycle_ctrl_decode u_decode (
      .i_instr (Instr),
      .o_class (w_class)
   );

   assign w_fetch_done  = (r_fetch_cnt == FETCH_LAST);
   assign w_mem_expired = TIMEOUT_EN && (r_mem_cnt == MEM_LAST);

   // The ALU operands must stay selected from EXEC through the final state,
   // since MEM addresses and WB results come straight off the ALU output.
   // LUI and FENCE never go through EXEC and leave the ALU idle.
   assign w_alu_phase = (r_state inside {EXEC, MEM, WB}) &&
                        (w_class != CLS_LUI) && (w_class != CLS_FENCE);

   // State register; Reset returns to FETCH from any state
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      if (Reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch-latency and MEM-wait counters, cleared whenever their state is left
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_fetch_cnt <= '0;
         r_mem_cnt   <= '0;
      end else begin
         r_fetch_cnt <= ((r_state == FETCH) && !w_fetch_done) ? r_fetch_cnt + 4'd1 : '0;
         r_mem_cnt   <= ((r_state == MEM) && !DmemRdy) ? r_mem_cnt + MEM_CNT_W'(1) : '0;
      end
   end

   // Sticky exception flags, cleared only by Reset
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_halt    <= 1'b0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_halt    <= r_halt    | w_set_halt;
         r_illegal <= r_illegal | w_set_illegal;
         r_bus_err <= r_bus_err | w_set_bus_err;
      end
   end

   // Next-state and Moore-style output decode of state + Instr, masked by Reset
   always_comb begin
      w_state_nxt   = r_state;
      w_set_halt    = 1'b0;
      w_set_illegal = 1'b0;
      w_set_bus_err = 1'b0;
      PcWrEn        = 1'b0;
      IrWrEn        = 1'b0;
      JalPcSel      = 1'b0;
      BrPcSel       = 1'b0;
      AuipcSel      = 1'b0;
      Op2Sel        = 1'b0;
      RegWb         = SEL_REG_WB_ALU;
      RegWrEn       = 1'b0;
      DmemRdEn      = 1'b0;
      DmemWrEn      = 1'b0;
      InstrRetired  = 1'b0;

      case (r_state)
         FETCH: begin
            if (w_fetch_done) begin
               IrWrEn      = 1'b1;
               w_state_nxt = DECODE;
            end
         end

         DECODE: begin
            case (w_class)
               CLS_ILLEGAL: begin
                  w_state_nxt   = TRAP;
                  w_set_illegal = 1'b1;
               end
               CLS_ENV: begin
                  w_state_nxt = HALT;
                  w_set_halt  = 1'b1;
               end
               CLS_LUI, CLS_FENCE: w_state_nxt = WB;
               default:            w_state_nxt = EXEC;
            endcase
         end

         EXEC: begin
            if (w_class == CLS_BRANCH) begin
               // Not-taken branches still load Pc, with the Pc+4 path
               PcWrEn       = 1'b1;
               BrPcSel      = BrTaken;
               InstrRetired = 1'b1;
               w_state_nxt  = FETCH;
            end else if ((w_class == CLS_LOAD) || (w_class == CLS_STORE)) begin
               w_state_nxt = MEM;
            end else begin
               w_state_nxt = WB;
            end
         end

         MEM: begin
            DmemRdEn = (w_class == CLS_LOAD);
            DmemWrEn = (w_class == CLS_STORE);
            if (DmemRdy) begin
               if (w_class == CLS_LOAD) begin
                  w_state_nxt = WB;
               end else begin
                  PcWrEn       = 1'b1;
                  InstrRetired = 1'b1;
                  w_state_nxt  = FETCH;
               end
            end else if (w_mem_expired) begin
               w_state_nxt   = TRAP;
               w_set_bus_err = 1'b1;
            end
         end

         WB: begin
            // rd == x0 still writes; the register file discards it
            RegWrEn      = (w_class != CLS_FENCE);
            RegWb        = wb_sel(w_class);
            PcWrEn       = 1'b1;
            JalPcSel     = (w_class == CLS_JAL) || (w_class == CLS_JALR);
            InstrRetired = 1'b1;
            w_state_nxt  = FETCH;
         end

         HALT, TRAP: w_state_nxt = r_state;

         default: w_state_nxt = FETCH;
      endcase

      if (w_alu_phase) begin
         Op2Sel   = (w_class != CLS_OP) && (w_class != CLS_BRANCH);
         AuipcSel = (w_class == CLS_AUIPC) || (w_class == CLS_JAL);
      end

      Halt         = r_halt;
      IllegalInstr = r_illegal;
      BusErr       = r_bus_err;

      // Nothing may reach the datapath during the Reset cycle, whatever the state
      if (Reset) begin
         PcWrEn       = 1'b0;
         IrWrEn       = 1'b0;
         JalPcSel     = 1'b0;
         BrPcSel      = 1'b0;
         AuipcSel     = 1'b0;
         Op2Sel       = 1'b0;
         RegWb        = SEL_REG_WB_ALU;
         RegWrEn      = 1'b0;
         DmemRdEn     = 1'b0;
         DmemWrEn     = 1'b0;
         InstrRetired = 1'b0;
         Halt         = 1'b0;
         IllegalInstr = 1'b0;
         BusErr       = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: directed instruction sequences, a
// transaction-level model that lays out each instruction's cycle timeline,
// and one compare process checking all outputs every cycle.
module tb_rv_multicycle_ctrl;

   localparam int IMEM_LAT = 1;
   localparam int MEM_TO   = 8;

   logic        clk     = 1'b0;
   logic        Reset   = 1'b1;
   logic [31:0] Instr   = 32'h0;
   logic        BrTaken = 1'b0;
   logic        DmemRdy = 1'b0;
   logic        PcWrEn, IrWrEn, JalPcSel, BrPcSel, AuipcSel, Op2Sel;
   logic [1:0]  RegWb;
   logic        RegWrEn, DmemRdEn, DmemWrEn, InstrRetired;
   logic        Halt, IllegalInstr, BusErr;

   rv_multicycle_ctrl #(
      .IMEM_LATENCY (IMEM_LAT),
      .MEM_TIMEOUT  (MEM_TO)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .Instr        (Instr),
      .BrTaken      (BrTaken),
      .DmemRdy      (DmemRdy),
      .PcWrEn       (PcWrEn),
      .IrWrEn       (IrWrEn),
      .JalPcSel     (JalPcSel),
      .BrPcSel      (BrPcSel),
      .AuipcSel     (AuipcSel),
      .Op2Sel       (Op2Sel),
      .RegWb        (RegWb),
      .RegWrEn      (RegWrEn),
      .DmemRdEn     (DmemRdEn),
      .DmemWrEn     (DmemWrEn),
      .InstrRetired (InstrRetired),
      .Halt         (Halt),
      .IllegalInstr (IllegalInstr),
      .BusErr       (BusErr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_wr, ir_wr, jal, br, auipc, op2;
      logic [1:0] regwb;
      logic       reg_wr, rd_en, wr_en, retire, halt, ill, bus;
   } ctl_t;

   typedef struct packed {
      logic       exec, ld, st, branch, op2, auipc, jal, regwr, halts, illegal;
      logic [1:0] regwb;
   } props_t;

   ctl_t act;
   assign act = {PcWrEn, IrWrEn, JalPcSel, BrPcSel, AuipcSel, Op2Sel, RegWb,
                 RegWrEn, DmemRdEn, DmemWrEn, InstrRetired, Halt, IllegalInstr, BusErr};

   ctl_t exp_q[$];
   ctl_t cmp_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   ir_cyc   = -1;
   int   ret_cyc  = -1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Compare process: one expected control vector per cycle, sampled mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (IrWrEn === 1'b1) ir_cyc = cyc;
      if (InstrRetired === 1'b1) ret_cyc = cyc;
      if (exp_q.size() > 0) begin
         cmp_e = exp_q.pop_front();
         check($sformatf("cyc%0d_ctl", cyc), 32'(act), 32'(cmp_e));
      end
   end

   // Architectural properties of an instruction word, from the ISA opcode map
   function automatic props_t props(input logic [31:0] ins);
      props_t p;
      p = '0;
      if (ins[1:0] != 2'b11) begin
         p.illegal = 1'b1;
      end else begin
         case (ins[6:0])
            7'b0110111: begin p.regwr = 1; p.regwb = 2'd3; end                          // LUI
            7'b0010111: begin p.exec = 1; p.op2 = 1; p.auipc = 1; p.regwr = 1; end      // AUIPC
            7'b1101111: begin p.exec = 1; p.op2 = 1; p.auipc = 1; p.jal = 1;
                              p.regwr = 1; p.regwb = 2'd2; end                          // JAL
            7'b1100111: begin p.exec = 1; p.op2 = 1; p.jal = 1; p.regwr = 1;
                              p.regwb = 2'd2; end                                       // JALR
            7'b1100011: begin p.exec = 1; p.branch = 1; end                             // BRANCH
            7'b0000011: begin p.exec = 1; p.op2 = 1; p.ld = 1; p.regwr = 1;
                              p.regwb = 2'd1; end                                       // LOAD
            7'b0100011: begin p.exec = 1; p.op2 = 1; p.st = 1; end                      // STORE
            7'b0010011: begin p.exec = 1; p.op2 = 1; p.regwr = 1; end                   // OP-IMM
            7'b0110011: begin p.exec = 1; p.regwr = 1; end                              // OP
            7'b0001111: begin end                                                       // FENCE
            7'b1110011: begin
               if (ins[14:12] == 3'b000) p.halts = 1'b1;
               else                      p.illegal = 1'b1;
            end
            default: p.illegal = 1'b1;
         endcase
      end
      return p;
   endfunction

   // Drive one cycle's inputs just after the edge and queue its expected outputs
   task automatic step(input logic rst, input logic rdy, input logic br,
                       input logic [31:0] ins, input ctl_t e);
      @(posedge clk);
      #1;
      Reset   = rst;
      DmemRdy = rdy;
      BrTaken = br;
      Instr   = ins;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, Instr, '0);
   endtask

   // Lay out one instruction's timeline: FETCH, DECODE, then EXEC/MEM/WB as the
   // class requires. rdy_lat = MEM cycles with DmemRdy low (-1: never ready);
   // rst_at = MEM cycle on which Reset is asserted (-1: none); hold = cycles
   // observed in a terminal state. s returns the cycle number of the first FETCH.
   task automatic run_instr(input logic [31:0] ins, input logic br, input int rdy_lat,
                            input int rst_at, input int hold, output int s);
      props_t p;
      ctl_t   e;
      logic   rdy;
      p = props(ins);
      s = -1;
      for (int k = 0; k <= IMEM_LAT; k++) begin
         e = '0;
         e.ir_wr = (k == IMEM_LAT);
         step(1'b0, 1'b0, br, Instr, e);
         if (k == 0) s = cyc + 1;
      end
      // IR now holds the new word
      step(1'b0, 1'b0, br, ins, '0);
      if (p.illegal || p.halts) begin
         for (int k = 0; k < hold; k++) begin
            e = '0;
            e.halt = p.halts;
            e.ill  = p.illegal;
            step(1'b0, k[0], k[1], ins, e);
         end
         return;
      end
      if (p.exec) begin
         e = '0;
         e.op2   = p.op2;
         e.auipc = p.auipc;
         if (p.branch) begin
            e.pc_wr  = 1'b1;
            e.br     = br;
            e.retire = 1'b1;
         end
         step(1'b0, 1'b0, br, ins, e);
         if (p.branch) return;
      end
      if (p.ld || p.st) begin
         for (int j = 0; j < 4 * MEM_TO + 8; j++) begin
            rdy = (rdy_lat >= 0) && (j >= rdy_lat);
            if (j == rst_at) begin
               step(1'b1, rdy, br, ins, '0);
               return;
            end
            e = '0;
            e.op2   = p.op2;
            e.auipc = p.auipc;
            e.rd_en = p.ld;
            e.wr_en = p.st;
            if (rdy && p.st) begin
               e.pc_wr  = 1'b1;
               e.retire = 1'b1;
            end
            step(1'b0, rdy, br, ins, e);
            if (rdy) break;
            if (MEM_TO > 0 && j == MEM_TO - 1) begin
               for (int k = 0; k < hold; k++) begin
                  e = '0;
                  e.bus = 1'b1;
                  step(1'b0, k[0], k[1], ins, e);
               end
               return;
            end
         end
         if (p.st) return;
      end
      e = '0;
      e.op2    = p.op2;
      e.auipc  = p.auipc;
      e.reg_wr = p.regwr;
      e.regwb  = p.regwb;
      e.pc_wr  = 1'b1;
      e.jal    = p.jal;
      e.retire = 1'b1;
      step(1'b0, 1'b0, br, ins, e);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Retirement latency as seen on the DUT, against the hand-computed count
   task automatic check_lat(input string name, input int s, input int want);
      settle();
      check(name, 32'(ret_cyc - s + 1), 32'(want));
   endtask

   initial begin
      int s;
      do_reset(2);

      run_instr(32'h00500093, 1'b0, 0, -1, 0, s);          // ADDI x1,x0,5
      check_lat("addi_latency", s, 5);
      check("addi_irwr_offset", 32'(ir_cyc - s), 32'd1);
      check("addi_retire_offset", 32'(ret_cyc - s), 32'd4);

      run_instr(32'h0000A103, 1'b0, 3, -1, 0, s);          // LW, DmemRdy low 3 cycles
      check_lat("lw_wait3_latency", s, 9);
      run_instr(32'h00208463, 1'b1, 0, -1, 0, s);          // BEQ taken
      check_lat("beq_taken_latency", s, 4);
      run_instr(32'h00208463, 1'b0, 0, -1, 0, s);          // BEQ not taken
      check_lat("beq_not_taken_latency", s, 4);
      run_instr(32'h010000EF, 1'b0, 0, -1, 0, s);          // JAL x1,16
      check_lat("jal_latency", s, 5);
      run_instr(32'h00008067, 1'b0, 0, -1, 0, s);          // JALR x0,0(x1)
      check_lat("jalr_latency", s, 5);
      run_instr(32'h123452B7, 1'b0, 0, -1, 0, s);          // LUI
      check_lat("lui_latency", s, 4);
      run_instr(32'h00001197, 1'b0, 0, -1, 0, s);          // AUIPC
      check_lat("auipc_latency", s, 5);
      run_instr(32'h002081B3, 1'b1, 0, -1, 0, s);          // ADD
      check_lat("add_latency", s, 5);
      run_instr(32'h0FF0000F, 1'b0, 0, -1, 0, s);          // FENCE
      check_lat("fence_latency", s, 4);
      run_instr(32'h0020A223, 1'b0, 0, -1, 0, s);          // SW, ready at once
      check_lat("sw_latency", s, 5);
      run_instr(32'h0000A103, 1'b0, 0, -1, 0, s);          // LW, ready at once
      check_lat("lw_latency", s, 6);

      run_instr(32'h0000007F, 1'b0, 0, -1, 6, s);          // unknown opcode
      settle();
      check("illegal_sticky", 32'(IllegalInstr), 32'd1);
      do_reset(1);

      run_instr(32'h0020A223, 1'b0, -1, -1, 4, s);         // SW, DmemRdy stuck low
      settle();
      check("bus_err_sticky", 32'(BusErr), 32'd1);
      do_reset(1);

      run_instr(32'h00500093, 1'b0, 0, -1, 0, s);          // recovers after Reset
      check_lat("addi_after_trap_latency", s, 5);
      check("bus_err_cleared", 32'(BusErr), 32'd0);

      run_instr(32'h0020A223, 1'b0, -1, 2, 0, s);          // Reset lands mid-MEM
      run_instr(32'h00000073, 1'b0, 0, -1, 5, s);          // ECALL
      settle();
      check("halt_sticky", 32'(Halt), 32'd1);
      do_reset(1);

      run_instr(32'h00500090, 1'b0, 0, -1, 3, s);          // Instr[1:0] != 2'b11
      do_reset(1);
      run_instr(32'h00100073, 1'b0, 0, -1, 2, s);          // EBREAK
      do_reset(1);

      settle();
      check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
